// File: rtl/sha256_msg_scheduler.sv
// sha256_msg_scheduler: streaming SHA-256 message-schedule generator.
// Latches one 512-bit padded block and emits W[0]..W[63] with round index t
// (and round constant K[t]) on a valid/ready beat interface.
// Optional feature: define SHA256_KROM_EN to compile in the K constant ROM;
// without it k_o is tied to zero.
module sha256_msg_scheduler #(
  parameter int ROUNDS = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start_i,
  input  logic [511:0] block_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [31:0]  w_o,
  output logic [31:0]  k_o,
  output logic [5:0]   t_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [31:0] w_q, w_d;
  logic [5:0]  t_q, t_d;

  logic        loadEn;
  logic        acceptEn;
  logic        lastBeat;
  logic [31:0] newWord;

  // Small sigma functions of the SHA-256 message expansion
  function automatic logic [31:0] smallSigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] smallSigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Handshake decode: load only from IDLE, a beat is accepted whenever RUN sees ready
  always_comb begin
    loadEn   = (state_q == IDLE) && start_i;
    acceptEn = (state_q == RUN) && ready_i;
    lastBeat = acceptEn && (t_q == LAST_T);
  end

  // Next window word; values generated beyond W[63] are simply never emitted
  always_comb begin
    newWord = smallSigma1(win_q[14]) + win_q[9] + smallSigma0(win_q[1]) + win_q[0];
  end

  // State register; reset discards any in-flight block
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DONE lasts exactly one cycle, start is ignored outside IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (lastBeat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: valid only in RUN, done pulse is the single DONE cycle
  always_comb begin
    valid_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE: ;
      RUN: begin
        valid_o = 1'b1;
        busy_o  = 1'b1;
      end
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Window and output-word next values: load the block, shift on accept, hold on stall
  always_comb begin
    win_d = win_q;
    w_d   = w_q;
    t_d   = t_q;
    if (loadEn) begin
      for (int i = 0; i < 16; i++) begin
        win_d[i] = block_i[511 - 32*i -: 32];
      end
      w_d = block_i[511:480];
      t_d = 6'd0;
    end else if (acceptEn) begin
      for (int i = 0; i < 15; i++) begin
        win_d[i] = win_q[i + 1];
      end
      win_d[15] = newWord;
      if (lastBeat) begin
        w_d = 32'd0;
        t_d = 6'd0;
      end else begin
        w_d = win_q[1];
        t_d = t_q + 6'd1;
      end
    end
  end

  // Window and registered word/index outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= 32'd0;
      end
      w_q <= 32'd0;
      t_q <= 6'd0;
    end else begin
      win_q <= win_d;
      w_q   <= w_d;
      t_q   <= t_d;
    end
  end

  assign w_o = w_q;
  assign t_o = t_q;

`ifdef SHA256_KROM_EN
  localparam logic [31:0] KROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] k_q, k_d;

  // Round constant tracks the word: K[0] on load, K[t+1] on accept, cleared after the last beat
  always_comb begin
    k_d = k_q;
    if (loadEn) begin
      k_d = KROM[0];
    end else if (lastBeat) begin
      k_d = 32'd0;
    end else if (acceptEn) begin
      k_d = KROM[t_q + 6'd1];
    end
  end

  // Registered round constant, aligned with w_o
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      k_q <= 32'd0;
    end else begin
      k_q <= k_d;
    end
  end

  assign k_o = k_q;
`else
  assign k_o = 32'd0;
`endif

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// Self-checking bench for sha256_msg_scheduler: scoreboard of expected
// (t, W[t]) pairs built from a reference message-expansion model.
module tb_sha256_msg_scheduler;

  logic         CLK;
  logic         RST;
  logic         start_i;
  logic [511:0] block_i;
  logic         ready_i;
  logic         valid_o;
  logic [31:0]  w_o;
  logic [31:0]  k_o;
  logic [5:0]   t_o;
  logic         busy_o;
  logic         done_o;

  typedef struct packed {
    logic [5:0]  t;
    logic [31:0] w;
  } expWord_t;

  expWord_t expQ[$];

  int checkCount = 0;
  int failCount  = 0;
  int cycleCnt   = 0;
  int loadCycle  = 0;

  logic [511:0] abcBlock;
  logic [511:0] strayBlock;
  logic [511:0] blockB;
  logic [511:0] blockC;
  logic [31:0]  abcRef [5];

  sha256_msg_scheduler #(.ROUNDS(64)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .start_i (start_i),
    .block_i (block_i),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .w_o     (w_o),
    .k_o     (k_o),
    .t_o     (t_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  // Free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Cycle counter used to measure latencies and block periods
  always @(posedge CLK) cycleCnt <= cycleCnt + 1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] modelSigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] modelSigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h at cycle %0d", tag, observed, expected, cycleCnt);
    end
  endtask

  // Reference schedule: array form of the standard recurrence, pushed to the scoreboard
  task automatic pushBlock(input logic [511:0] blk);
    logic [31:0] w [64];
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = modelSigma1(w[i-2]) + w[i-7] + modelSigma0(w[i-15]) + w[i-16];
    for (int i = 0; i < 64; i++) expQ.push_back('{t: 6'(i), w: w[i]});
  endtask

  // Drive one block from IDLE; optionally stall randomly, pulse a stray start, or reset at a given t
  task automatic applyStimulus(input logic [511:0] blk, input bit randomStall, input bit isAbc,
                               input int strayStartT, input int resetT);
    int       accepted;
    int       budget;
    int       stalls;
    bit       aborted;
    expWord_t e;
    pushBlock(blk);
    block_i = blk;
    start_i = 1'b1;
    ready_i = 1'b0;
    @(posedge CLK); #1;
    start_i   = 1'b0;
    loadCycle = cycleCnt;
    checkOutput("loadBusy", 32'(busy_o), 32'd1);
    accepted = 0;
    budget   = 400;
    stalls   = 0;
    aborted  = 1'b0;
    while (accepted < 64 && budget > 0 && !aborted) begin
      ready_i = randomStall ? 1'($urandom_range(0, 1)) : 1'b1;
      e = expQ[0];
      checkOutput("valid", 32'(valid_o), 32'd1);
      checkOutput("word", w_o, e.w);
      checkOutput("index", 32'(t_o), 32'(e.t));
`ifdef SHA256_KROM_EN
      if (e.t == 6'd0)  checkOutput("kFirst", k_o, 32'h428a2f98);
      if (e.t == 6'd63) checkOutput("kLast", k_o, 32'hc67178f2);
`else
      checkOutput("kZero", k_o, 32'd0);
`endif
      if (isAbc && e.t >= 6'd16 && e.t <= 6'd20)
        checkOutput("abcWord", w_o, abcRef[int'(e.t) - 16]);
      if (int'(e.t) == resetT) begin
        RST = 1'b0;
        #1;
        checkOutput("rstValid", 32'(valid_o), 32'd0);
        checkOutput("rstBusy", 32'(busy_o), 32'd0);
        checkOutput("rstIndex", 32'(t_o), 32'd0);
        checkOutput("rstWord", w_o, 32'd0);
        checkOutput("rstDone", 32'(done_o), 32'd0);
        #1;
        RST = 1'b1;
        expQ.delete();
        aborted = 1'b1;
      end else begin
        if (int'(e.t) == strayStartT) begin
          start_i = 1'b1;
          block_i = strayBlock;
        end
        if (ready_i) begin
          void'(expQ.pop_front());
          accepted++;
        end else begin
          stalls++;
        end
        @(posedge CLK); #1;
        start_i = 1'b0;
        block_i = blk;
        budget--;
      end
    end
    if (!aborted) begin
      if (accepted < 64) begin
        checkOutput("timeout", 32'(accepted), 32'd64);
        expQ.delete();
      end else begin
        checkOutput("doneHigh", 32'(done_o), 32'd1);
        checkOutput("doneValid", 32'(valid_o), 32'd0);
        checkOutput("doneBusy", 32'(busy_o), 32'd1);
        checkOutput("doneLatency", 32'(cycleCnt - loadCycle), 32'(64 + stalls));
        @(posedge CLK); #1;
        checkOutput("idleDone", 32'(done_o), 32'd0);
        checkOutput("idleBusy", 32'(busy_o), 32'd0);
      end
    end
  endtask

  // Test sequence
  initial begin
    int t0First;
    abcBlock   = {32'h61626380, 448'h0, 32'h00000018};
    abcRef[0]  = 32'h61626380;
    abcRef[1]  = 32'h000F0000;
    abcRef[2]  = 32'h7DA86405;
    abcRef[3]  = 32'h600003C6;
    abcRef[4]  = 32'h3E9D7B78;
    for (int i = 0; i < 16; i++) begin
      strayBlock[511 - 32*i -: 32] = $urandom;
      blockB[511 - 32*i -: 32]     = $urandom;
      blockC[511 - 32*i -: 32]     = $urandom;
    end

    RST     = 1'b0;
    start_i = 1'b0;
    ready_i = 1'b0;
    block_i = '0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("resetValid", 32'(valid_o), 32'd0);
    checkOutput("resetWord", w_o, 32'd0);
    checkOutput("resetK", k_o, 32'd0);
    checkOutput("resetIndex", 32'(t_o), 32'd0);
    checkOutput("resetBusy", 32'(busy_o), 32'd0);
    checkOutput("resetDone", 32'(done_o), 32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    $display("[TB] abc block, no stalls, then back-to-back block");
    applyStimulus(abcBlock, 1'b0, 1'b1, -1, -1);
    t0First = loadCycle;
    applyStimulus(blockB, 1'b0, 1'b0, -1, -1);
    checkOutput("blockPeriod", 32'(loadCycle - t0First), 32'd66);

    $display("[TB] abc block with random stalls");
    applyStimulus(abcBlock, 1'b1, 1'b1, -1, -1);

    $display("[TB] stray start at t=10");
    applyStimulus(abcBlock, 1'b0, 1'b1, 10, -1);

    $display("[TB] reset at t=30, then a fresh block");
    applyStimulus(abcBlock, 1'b0, 1'b1, -1, 30);
    applyStimulus(blockC, 1'b0, 1'b0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/sha256_msg_scheduler.md
# sha256_msg_scheduler

Streaming SHA-256 message-schedule generator: the producer end of the per-round `w_i`/`k_i` interface consumed by the 64-stage compression round pipeline. It latches one 512-bit padded message block and emits W[0]..W[63], one word per accepted beat. Each word is paired with its round constant K[t] and round index t. It sits between the block-padding logic and the round pipeline in each SHA256 core.

## Interface
Parameters:
- `ROUNDS`, 64: number of schedule words emitted per block; fixed at 64 for SHA-256, and only 64 is a legal value.

Ports:
- `CLK`: input, 1 bit. Single clock; all state updates on the rising edge.
- `RST`: input, 1 bit. Reset, asynchronous and active-low.
- `start_i`: input, 1 bit. Load request; sampled only in IDLE.
- `block_i`: input, 512 bits. Padded block; W[0] = `block_i[511:480]`, …, W[15] = `block_i[31:0]`.
- `ready_i`: input, 1 bit. Downstream accepts the current word.
- `valid_o`: output, 1 bit. `w_o`, `k_o` and `t_o` are valid.
- `w_o`: output, 32 bits. Schedule word W[t].
- `k_o`: output, 32 bits. Round constant K[t]; see Configuration.
- `t_o`: output, 6 bits. Round index t.
- `busy_o`: output, 1 bit. High in RUN and DONE.
- `done_o`: output, 1 bit. One-cycle pulse after W[63] is accepted.

## Operation
- States:
  - IDLE → RUN when `start_i`=1; the block is latched into window win[0..15] and t=0.
  - RUN → DONE on acceptance of t=63.
  - DONE → IDLE unconditionally after one cycle.
- Window: win[0] = W[t], win[15] = W[t+15].
- Output in RUN: `w_o` = win[0] and `valid_o` = 1.
- A beat is accepted when `valid_o` & `ready_i`. On acceptance:
  - win shifts down by one;
  - win[15] ← σ1(win[14]) + win[9] + σ0(win[1]) + win[0], computed modulo 2^32;
  - t increments.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
- σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Generated words are needed only up to t=47. Expansion continues past that point and the surplus results are don't-care.
- Stall: when `ready_i`=0, `w_o`, `k_o`, `t_o` and `valid_o` hold unchanged.
- `start_i` is ignored while `busy_o`=1. It is honoured again in IDLE.
- Reset mid-block: all state and outputs clear immediately. The in-flight block is discarded and no `done_o` is produced.
- Reset values: `valid_o`=0, `w_o`=0, `k_o`=0, `t_o`=0, `busy_o`=0, `done_o`=0; state = IDLE.

## Timing
- `start_i` sampled high at edge N → `valid_o`=1 with t=0 and `w_o`=W[0] after edge N, i.e. 1-cycle load latency.
- With `ready_i` held high, t=0..63 appear on 64 consecutive cycles, one word per cycle with no bubbles.
- `done_o` is high for exactly one cycle, the cycle after t=63 is accepted; `valid_o`=0 in that cycle.
- Back-to-back blocks: the earliest next `start_i` is sampled in the IDLE cycle following DONE. The minimum block period is 66 cycles.
- Each stall cycle adds exactly one cycle to the block time.

## Configuration
- `SHA256_KROM_EN` defined:
  - a 64-entry K constant ROM is compiled in;
  - `k_o` = K[t], registered alongside `w_o` (K[0]=0x428a2f98, K[63]=0xc67178f2).
- `SHA256_KROM_EN` undefined:
  - the ROM is omitted and `k_o` is tied to 0;
  - the round pipeline supplies K from its own per-stage constants;
  - all other behaviour is identical.

## Test plan
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), `ready_i`=1 → W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6, W20=0x3E9D7B78. The bench checks all 64 words against a software model, and `done_o` pulses at edge N+65.
- Random stalls (`ready_i` ~50% duty) with the same block → identical W sequence. Outputs are stable during every stall cycle, and no t value is repeated or skipped.
- `start_i` pulsed at t=10 with a different block → ignored. The "abc" sequence completes unchanged.
- `RST` asserted at t=30 → `valid_o`, `busy_o` and `t_o` go to 0 immediately. A new start after release produces W[0] of the new block.
- With `SHA256_KROM_EN`: `k_o` = 0x428a2f98 at t=0 and 0xc67178f2 at t=63. Without it: `k_o`=0 for all t.
- Two blocks issued back-to-back at the earliest legal start → second block's t=0 appears 66 cycles after the first block's t=0, and no words of the two blocks are interleaved.
